gcn_coo_aggregate: RTL and testbench

- Downstream stage of the GCN feature-transformation datapath.
- Consumes the transformed matrix FM (FEATURE_ROWS x WEIGHT_COLS dot products) and walks the COO adjacency list from COO memory.
- Accumulates neighbour rows per node, then computes a per-node argmax that drives max_addi_answer.
- Owns the coo_address port of the GCN top.

---
 rtl/gcn_pkg.sv | 34 +++
 rtl/gcn_argmax_row.sv | 30 +++
 rtl/gcn_coo_aggregate.sv | 148 ++++++++++++++
 tb/tb_gcn_coo_aggregate.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// ============================================================================
// gcn_pkg : shared sizes, element/row types and FSM encoding for COO aggregation
// Rev 1.0
// ============================================================================
`default_nettype none

package gcn_pkg;

   localparam int FEATURE_ROWS      = 6;
   localparam int WEIGHT_COLS       = 3;
   localparam int DOT_PROD_WIDTH    = 16;
   localparam int COO_NUM_OF_COLS   = 6;
   localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
   localparam int AGG_WIDTH         = DOT_PROD_WIDTH + 4;
   localparam int MAX_ADDRESS_WIDTH = 2;

   typedef logic [DOT_PROD_WIDTH-1:0] fm_elem_t;
   typedef logic [AGG_WIDTH-1:0]      agg_elem_t;

   typedef fm_elem_t  fm_row_t  [0:WEIGHT_COLS-1];
   typedef agg_elem_t agg_row_t [0:WEIGHT_COLS-1];

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_FETCH  = 3'd2,
      S_DRAIN  = 3'd3,
      S_ARGMAX = 3'd4,
      S_DONE   = 3'd5
   } agg_state_e;

endpackage

`default_nettype wire

// File: rtl/gcn_argmax_row.sv
// ============================================================================
// gcn_argmax_row : combinational argmax over one aggregated row, ties -> lowest
// Rev 1.0
// ============================================================================
`default_nettype none

module gcn_argmax_row
   import gcn_pkg::*;
(
   input  agg_row_t                      i_row,
   output logic [MAX_ADDRESS_WIDTH-1:0]  o_idx
);

   agg_elem_t w_best;

   always_comb begin
      w_best = i_row[0];
      o_idx  = '0;
      // Strict compare keeps the earliest column on equal values.
      for (int c = 1; c < WEIGHT_COLS; c++) begin
         if (i_row[c] > w_best) begin
            w_best = i_row[c];
            o_idx  = MAX_ADDRESS_WIDTH'(c);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/gcn_coo_aggregate.sv
// ============================================================================
// gcn_coo_aggregate : walks the COO edge list, sums neighbour FM rows per node
// and registers a per-node argmax. Optional macro GCN_SELF_LOOP_EN seeds each
// node's accumulator with its own FM row (A+I aggregation).
// Rev 1.0
// ============================================================================
`default_nettype none

module gcn_coo_aggregate
   import gcn_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DOT_PROD_WIDTH-1:0]     fm_in [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1],
   input  logic [COO_BW-1:0]             coo_in [0:1],
   output logic [COO_BW-1:0]             coo_address,
   output logic                          done,
   output logic [MAX_ADDRESS_WIDTH-1:0]  max_addi_answer [0:FEATURE_ROWS-1]
);

   localparam logic [COO_BW-1:0] c_LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);
   localparam logic [COO_BW:0]   c_NUM_ROWS  = (COO_BW + 1)'(FEATURE_ROWS);

   agg_state_e                    r_state;
   agg_state_e                    w_next;
   logic [COO_BW-1:0]             r_e;
   logic [COO_BW-1:0]             r_addr;
   logic                          r_done;
   agg_row_t                      r_agg [0:FEATURE_ROWS-1];
   logic [MAX_ADDRESS_WIDTH-1:0]  r_ans [0:FEATURE_ROWS-1];
   logic [MAX_ADDRESS_WIDTH-1:0]  w_ans [0:FEATURE_ROWS-1];
   agg_row_t                      w_add [0:FEATURE_ROWS-1];
   logic [COO_BW-1:0]             w_src;
   logic [COO_BW-1:0]             w_dst;
   logic                          w_edge_ok;
   logic                          w_acc_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_acc_en = 1'b0;
      case (r_state)
         S_IDLE:   if (start) w_next = S_INIT;
         S_INIT:   w_next = S_FETCH;
         S_FETCH: begin
            // The first FETCH cycle has no returned edge yet.
            w_acc_en = (r_e != '0);
            if (r_e == c_LAST_EDGE) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_acc_en = 1'b1;
            w_next   = S_ARGMAX;
         end
         S_ARGMAX: w_next = S_DONE;
         S_DONE:   if (start) w_next = S_INIT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_src     = coo_in[0];
      w_dst     = coo_in[1];
      w_edge_ok = ({1'b0, w_src} < c_NUM_ROWS) && ({1'b0, w_dst} < c_NUM_ROWS);
      for (int i = 0; i < FEATURE_ROWS; i++) begin
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            w_add[i][c] = '0;
            if (w_edge_ok) begin
               if (w_dst == COO_BW'(i))
                  w_add[i][c] = w_add[i][c] + AGG_WIDTH'(fm_in[w_src][c]);
               if ((w_src == COO_BW'(i)) && (w_src != w_dst))
                  w_add[i][c] = w_add[i][c] + AGG_WIDTH'(fm_in[w_dst][c]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e    <= '0;
         r_addr <= '0;
         r_done <= 1'b0;
         for (int i = 0; i < FEATURE_ROWS; i++) begin
            r_ans[i] <= '0;
            for (int c = 0; c < WEIGHT_COLS; c++) r_agg[i][c] <= '0;
         end
      end else begin
         case (r_state)
            S_INIT: begin
               r_e    <= '0;
               r_addr <= '0;
               for (int i = 0; i < FEATURE_ROWS; i++) begin
                  for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef GCN_SELF_LOOP_EN
                     r_agg[i][c] <= AGG_WIDTH'(fm_in[i][c]);
`else
                     r_agg[i][c] <= '0;
`endif
                  end
               end
            end
            S_FETCH: begin
               if (r_e != c_LAST_EDGE) begin
                  r_e    <= r_e + COO_BW'(1);
                  r_addr <= r_e + COO_BW'(1);
               end
            end
            S_ARGMAX: begin
               for (int i = 0; i < FEATURE_ROWS; i++) r_ans[i] <= w_ans[i];
            end
            default: ;
         endcase

         if (w_acc_en) begin
            for (int i = 0; i < FEATURE_ROWS; i++) begin
               for (int c = 0; c < WEIGHT_COLS; c++)
                  r_agg[i][c] <= r_agg[i][c] + w_add[i][c];
            end
         end

         // done rises one cycle into DONE and falls as soon as a restart is taken.
         r_done <= (r_state == S_DONE) && !start;
      end
   end

   generate
      for (genvar i = 0; i < FEATURE_ROWS; i++) begin : g_argmax
         gcn_argmax_row u_argmax (
            .i_row (r_agg[i]),
            .o_idx (w_ans[i])
         );
         assign max_addi_answer[i] = r_ans[i];
      end
   endgenerate

   assign coo_address = r_addr;
   assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gcn_coo_aggregate.sv
// ============================================================================
// tb_gcn_coo_aggregate : directed vector table plus reset/start corner cases
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gcn_coo_aggregate;

   typedef struct packed {
      logic [0:5][0:2][15:0] fm;
      logic [0:5][0:1][2:0]  edges;
      logic [0:5][1:0]       ans;
   } vec_t;

   localparam int NV = 6;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] fm_in [0:5][0:2];
   logic [2:0]  coo_in [0:1];
   logic [2:0]  coo_address;
   logic        done;
   logic [1:0]  max_addi_answer [0:5];

   logic [2:0]  mem_s [0:7];
   logic [2:0]  mem_d [0:7];

   vec_t        vecs [0:NV-1];
   int          n_vec;
   int          n_fail;

   gcn_coo_aggregate dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .fm_in           (fm_in),
      .coo_in          (coo_in),
      .coo_address     (coo_address),
      .done            (done),
      .max_addi_answer (max_addi_answer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // COO memory with one cycle of read latency
   always @(posedge clk) begin
      coo_in[0] <= mem_s[coo_address];
      coo_in[1] <= mem_d[coo_address];
   end

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic run_vec(input int idx, input int poke);
      int n;
      for (int i = 0; i < 6; i++)
         for (int c = 0; c < 3; c++) fm_in[i][c] = vecs[idx].fm[i][c];
      for (int k = 0; k < 6; k++) begin
         mem_s[k] = vecs[idx].edges[k][0];
         mem_d[k] = vecs[idx].edges[k][1];
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("v%0d done_drop", idx), int'(done), 0);
      n = 0;
      while (!done && n < 40) begin
         start = (n == poke);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check($sformatf("v%0d latency", idx), n, 10);
      for (int i = 0; i < 6; i++)
         check($sformatf("v%0d ans[%0d]", idx, i), int'(max_addi_answer[i]), int'(vecs[idx].ans[i]));
      check($sformatf("v%0d addr_hold", idx), int'(coo_address), 5);
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      reset  = 1'b1;
      start  = 1'b0;
      for (int i = 0; i < 6; i++)
         for (int c = 0; c < 3; c++) fm_in[i][c] = '0;
      for (int k = 0; k < 8; k++) begin
         mem_s[k] = '0;
         mem_d[k] = '0;
      end

      // basic: edges (0,1),(2,2)x5
      vecs[0].fm    = '0;
      vecs[0].fm[0] = {16'd1, 16'd5, 16'd2};
      vecs[0].fm[1] = {16'd0, 16'd0, 16'd3};
      vecs[0].edges = {3'd0,3'd1, 3'd2,3'd2, 3'd2,3'd2, 3'd2,3'd2, 3'd2,3'd2, 3'd2,3'd2};
      // neighbour dominance: edges (3,4),(5,5)x5
      vecs[1].fm    = '0;
      vecs[1].fm[3] = {16'd9, 16'd0, 16'd0};
      vecs[1].fm[4] = {16'd0, 16'd0, 16'd10};
      vecs[1].edges = {3'd3,3'd4, 3'd5,3'd5, 3'd5,3'd5, 3'd5,3'd5, 3'd5,3'd5, 3'd5,3'd5};
      // out-of-range: (6,0),(7,7)x5
      vecs[2].fm    = '0;
      vecs[2].fm[0] = {16'd0, 16'd4, 16'd0};
      vecs[2].edges = {3'd6,3'd0, 3'd7,3'd7, 3'd7,3'd7, 3'd7,3'd7, 3'd7,3'd7, 3'd7,3'd7};
      // ring 0-1-2-3-4-5-0
      vecs[3].fm    = {16'd3,16'd0,16'd0, 16'd0,16'd3,16'd0, 16'd0,16'd0,16'd3,
                       16'd3,16'd0,16'd0, 16'd0,16'd3,16'd0, 16'd0,16'd0,16'd3};
      vecs[3].edges = {3'd0,3'd1, 3'd1,3'd2, 3'd2,3'd3, 3'd3,3'd4, 3'd4,3'd5, 3'd5,3'd0};
      // self-edge counted once: (0,0),(1,0),(5,5)x4
      vecs[4].fm    = '0;
      vecs[4].fm[0] = {16'd3, 16'd0, 16'd0};
`ifdef GCN_SELF_LOOP_EN
      vecs[4].fm[1] = {16'd0, 16'd7, 16'd0};
`else
      vecs[4].fm[1] = {16'd0, 16'd4, 16'd0};
`endif
      vecs[4].edges = {3'd0,3'd0, 3'd1,3'd0, 3'd5,3'd5, 3'd5,3'd5, 3'd5,3'd5, 3'd5,3'd5};
      // overflow bound: all FFFF, every edge (0,1)
      vecs[5].fm    = '1;
      vecs[5].edges = {3'd0,3'd1, 3'd0,3'd1, 3'd0,3'd1, 3'd0,3'd1, 3'd0,3'd1, 3'd0,3'd1};

`ifdef GCN_SELF_LOOP_EN
      vecs[0].ans = {2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      vecs[1].ans = {2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
      vecs[2].ans = {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      vecs[3].ans = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      vecs[4].ans = {2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      vecs[0].ans = {2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      vecs[1].ans = {2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
      vecs[2].ans = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      vecs[3].ans = {2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      vecs[4].ans = {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      vecs[5].ans = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

      repeat (3) @(posedge clk);
      #1;
      check("rst done", int'(done), 0);
      check("rst addr", int'(coo_address), 0);
      for (int i = 0; i < 6; i++)
         check($sformatf("rst ans[%0d]", i), int'(max_addi_answer[i]), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Back-to-back runs: every run after the first restarts from DONE.
      for (int v = 0; v < NV; v++) run_vec(v, -1);

      // start pulsed during FETCH must not disturb the run
      run_vec(1, 3);

      // reset during FETCH cycle 3 aborts cleanly
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("fetch3 addr", int'(coo_address), 3);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst done", int'(done), 0);
      check("midrst addr", int'(coo_address), 0);
      for (int i = 0; i < 6; i++)
         check($sformatf("midrst ans[%0d]", i), int'(max_addi_answer[i]), 0);
      repeat (12) @(posedge clk);
      #1;
      check("midrst no_done", int'(done), 0);

      run_vec(0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
